slot_pin_owner_ctrl: RTL

//  Per-slot pin ownership controller between peripheral cores and one expansion slot's IOBUF bank.

---
 rtl/slot_pin_owner_ctrl_if.sv | 17 +
 rtl/slot_pin_owner_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/slot_pin_owner_ctrl_if.sv
// slot_pin_owner_ctrl_if: config request/response handshake between a slot owner controller and its configuring agent
//   cfg_valid/cfg_ready  request handshake (accepted when both high)
//   cfg_pin/en/src       target pin, assign(1)/release(0), new owner
//   cfg_done/cfg_err     1-cycle commit / reject pulses
interface slot_pin_owner_ctrl_if #(
  parameter int SRC_W = 2
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [4:0]       cfg_pin;
  logic             cfg_en;
  logic [SRC_W-1:0] cfg_src;
  logic             cfg_done;
  logic             cfg_err;
  modport master (output cfg_valid, cfg_pin, cfg_en, cfg_src, input cfg_ready, cfg_done, cfg_err);
  modport slave  (input cfg_valid, cfg_pin, cfg_en, cfg_src, output cfg_ready, cfg_done, cfg_err);
endinterface

// File: rtl/slot_pin_owner_ctrl.sv
// slot_pin_owner_ctrl: per-slot pin ownership mux with tri-state dead time on reassignment
//   clk, resetn           clock, async active-low reset
//   cfg                   config handshake (slot_pin_owner_ctrl_if.slave)
//   src_out, src_outen    per-core pin values/enables, core k at [k*NUM_PINS +: NUM_PINS]
//   src_in                slot inputs broadcast to all cores
//   slot_in/out/outen     IOBUF bank side (T = ~slot_outen)
//   force_off             globally disables all output enables, owner table kept
//   pin_owned             1 = pin has an owner
//   Macro SLOT_IN_SYNC_EN: when defined, slot_in goes through a 2-flop synchronizer
module slot_pin_owner_ctrl #(
  parameter int NUM_PINS    = 22,
  parameter int NUM_SRC     = 4,
  parameter int DEAD_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  slot_pin_owner_ctrl_if.slave        cfg,
  input  logic [NUM_SRC*NUM_PINS-1:0] src_out,
  input  logic [NUM_SRC*NUM_PINS-1:0] src_outen,
  output logic [NUM_PINS-1:0]         src_in,
  input  logic [NUM_PINS-1:0]         slot_in,
  output logic [NUM_PINS-1:0]         slot_out,
  output logic [NUM_PINS-1:0]         slot_outen,
  input  logic                        force_off,
  output logic [NUM_PINS-1:0]         pin_owned
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [4:0]          pin_q, pin_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic                err_q, err_d;
  logic [SRC_W-1:0]    owner_q [NUM_PINS];
  logic [SRC_W-1:0]    owner_d [NUM_PINS];
  logic [NUM_PINS-1:0] owned_q, owned_d;
  logic [NUM_PINS-1:0] drain_q, drain_d;
  logic [NUM_PINS-1:0] slot_out_q, slot_out_d;
  logic [NUM_PINS-1:0] slot_outen_q, slot_outen_d;
  logic [NUM_PINS-1:0] so_a [NUM_SRC];
  logic [NUM_PINS-1:0] oe_a [NUM_SRC];
  logic                req_bad;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
    assign so_a[k] = src_out[k*NUM_PINS +: NUM_PINS];
    assign oe_a[k] = src_outen[k*NUM_PINS +: NUM_PINS];
  end

  assign req_bad = (int'(cfg.cfg_pin) >= NUM_PINS) || (cfg.cfg_en && int'(cfg.cfg_src) >= NUM_SRC);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pin_d   = pin_q;
    src_d   = src_q;
    err_d   = 1'b0;
    owner_d = owner_q;
    owned_d = owned_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: if (cfg.cfg_valid) begin
        if (req_bad) begin
          err_d = 1'b1;
        end else if (cfg.cfg_en && owned_q[cfg.cfg_pin] && owner_q[cfg.cfg_pin] != cfg.cfg_src) begin
          // pin is being driven by another core: tri-state it before handing over
          drain_d[cfg.cfg_pin] = 1'b1;
          cnt_d   = 8'(DEAD_CYCLES);
          pin_d   = cfg.cfg_pin;
          src_d   = cfg.cfg_src;
          state_d = DRAIN;
        end else begin
          owned_d[cfg.cfg_pin] = cfg.cfg_en;
          if (cfg.cfg_en) owner_d[cfg.cfg_pin] = cfg.cfg_src;
          state_d = COMMIT;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          owner_d[pin_q] = src_q;
          drain_d[pin_q] = 1'b0;
          state_d        = COMMIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slot_out_d   = '0;
    slot_outen_d = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      slot_out_d[i]   = owned_q[i] & so_a[owner_q[i]][i];
      slot_outen_d[i] = owned_q[i] & ~drain_q[i] & ~force_off & oe_a[owner_q[i]][i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pin_q        <= '0;
      src_q        <= '0;
      err_q        <= 1'b0;
      owner_q      <= '{default: '0};
      owned_q      <= '0;
      drain_q      <= '0;
      slot_out_q   <= '0;
      slot_outen_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pin_q        <= pin_d;
      src_q        <= src_d;
      err_q        <= err_d;
      owner_q      <= owner_d;
      owned_q      <= owned_d;
      drain_q      <= drain_d;
      slot_out_q   <= slot_out_d;
      slot_outen_q <= slot_outen_d;
    end
  end

`ifdef SLOT_IN_SYNC_EN
  logic [NUM_PINS-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= slot_in;
      sync2_q <= sync1_q;
    end
  end
  assign src_in = sync2_q;
`else
  assign src_in = slot_in;
`endif

  assign slot_out      = slot_out_q;
  assign slot_outen    = slot_outen_q;
  assign pin_owned     = owned_q;
  assign cfg.cfg_ready = (state_q == IDLE);
  assign cfg.cfg_done  = (state_q == COMMIT);
  assign cfg.cfg_err   = err_q;
endmodule
